// File: rtl/dreq_rdma_rd_sched.sv
// Round-robin read-request scheduler in front of the RDMA read parser, with a
// per-requester outstanding-command cap released by completion pulses.
//
// state   | meaning
// ST_IDLE | arbitrating; one-cycle ready pulse to the granted requester
// ST_SEND | holding the latched request on m_req until the parser accepts it
module dreq_rdma_rd_sched #(
    parameter int N_REQ     = 4,
    parameter int DREQ_BITS = 128,
    parameter int MAX_OUTST = 8,
    parameter int CRED_BITS = 4,
    parameter int ID_BITS   = $clog2(N_REQ)
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [N_REQ-1:0]           s_req_valid,
    output logic [N_REQ-1:0]           s_req_ready,
    input  logic [N_REQ*DREQ_BITS-1:0] s_req_data,
    output logic                       m_req_valid,
    input  logic                       m_req_ready,
    output logic [DREQ_BITS-1:0]       m_req_data,
    output logic [ID_BITS-1:0]         m_req_src,
    input  logic                       cpl_valid,
    input  logic [ID_BITS-1:0]         cpl_id,
    input  logic [N_REQ-1:0]           en,
    output logic [N_REQ*CRED_BITS-1:0] outst,
    output logic                       busy,
    output logic                       err
);

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    localparam logic [CRED_BITS-1:0] CAP      = CRED_BITS'(MAX_OUTST);
    localparam logic [ID_BITS-1:0]   LAST_IDX = ID_BITS'(N_REQ - 1);

    state_t               state, state_nxt;
    logic [ID_BITS-1:0]   rr_ptr;
    logic [CRED_BITS-1:0] cnt [N_REQ];
    logic [N_REQ-1:0]     elig;
    logic                 gnt_found;
    logic [ID_BITS-1:0]   gnt_idx;
    logic [ID_BITS-1:0]   scan_idx;
    logic                 gnt_fire;
    logic                 snd_done;
    logic [N_REQ-1:0]     inc_v;
    logic [N_REQ-1:0]     dec_v;
    logic [N_REQ-1:0]     under_v;
    logic                 cpl_bad;

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = s_req_valid[i] & en[i] & (cnt[i] < CAP);
        end
    end

    // First eligible requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = ID_BITS'((int'(rr_ptr) + k) % N_REQ);
            if (!gnt_found && elig[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        s_req_ready = '0;
        gnt_fire    = 1'b0;
        snd_done    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_found && !areset) begin
                    s_req_ready = N_REQ'(1) << gnt_idx;
                    gnt_fire    = 1'b1;
                    state_nxt   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (m_req_ready) begin
                    snd_done  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign m_req_valid = (state == ST_SEND);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            m_req_data <= '0;
            m_req_src  <= '0;
        end else begin
            state <= state_nxt;
            if (gnt_fire) begin
                m_req_data <= s_req_data[int'(gnt_idx)*DREQ_BITS +: DREQ_BITS];
                m_req_src  <= gnt_idx;
            end
            if (snd_done) begin
                rr_ptr <= (m_req_src == LAST_IDX) ? '0 : m_req_src + 1'b1;
            end
        end
    end

    // A grant and a completion hitting the same counter cancel out.
    always_comb begin
        inc_v   = '0;
        dec_v   = '0;
        under_v = '0;
        for (int i = 0; i < N_REQ; i++) begin
            inc_v[i]   = gnt_fire && (gnt_idx == ID_BITS'(i));
            dec_v[i]   = cpl_valid && (cpl_id == ID_BITS'(i));
            under_v[i] = dec_v[i] && !inc_v[i] && (cnt[i] == '0);
        end
        cpl_bad = cpl_valid && !(|dec_v);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt[i] <= '0;
            end
            err <= 1'b0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (inc_v[i] && !dec_v[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (dec_v[i] && !inc_v[i] && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
            if (cpl_bad || (|under_v)) begin
                err <= 1'b1;
            end
        end
    end

    always_comb begin
        outst = '0;
        for (int i = 0; i < N_REQ; i++) begin
            outst[i*CRED_BITS +: CRED_BITS] = cnt[i];
        end
    end

    assign busy = (state != ST_IDLE) || (|outst);

endmodule

// File: tb/tb_dreq_rdma_rd_sched.sv
// Bench for dreq_rdma_rd_sched: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_dreq_rdma_rd_sched;

    localparam int N    = 4;
    localparam int DW   = 128;
    localparam int MAXO = 8;
    localparam int CB   = 4;
    localparam int IB   = 2;

    logic            aclk = 1'b0;
    logic            areset;
    logic [N-1:0]    s_req_valid;
    logic [N-1:0]    s_req_ready;
    logic [N*DW-1:0] s_req_data;
    logic            m_req_valid;
    logic            m_req_ready;
    logic [DW-1:0]   m_req_data;
    logic [IB-1:0]   m_req_src;
    logic            cpl_valid;
    logic [IB-1:0]   cpl_id;
    logic [N-1:0]    en;
    logic [N*CB-1:0] outst;
    logic            busy;
    logic            err;

    int checks = 0;
    int errors = 0;

    dreq_rdma_rd_sched #(
        .N_REQ(N), .DREQ_BITS(DW), .MAX_OUTST(MAXO), .CRED_BITS(CB), .ID_BITS(IB)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_data(s_req_data),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_req_data(m_req_data), .m_req_src(m_req_src),
        .cpl_valid(cpl_valid), .cpl_id(cpl_id), .en(en),
        .outst(outst), .busy(busy), .err(err)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic grant_one(input int id);
        s_req_valid = N'(1) << id;
        tick();
        s_req_valid = '0;
        tick();
    endtask

    // Transaction-level model: one slot for the request on its way to the
    // parser, a pointer for round-robin, and plain integer credit counts.
    int            mcnt [N];
    bit            mpend;
    int            msrc;
    logic [DW-1:0] mdata;
    int            mrr;
    bit            merr;

    always @(negedge aclk) begin : model
        logic [N-1:0]    elig;
        logic [N-1:0]    exp_rdy;
        logic [N*CB-1:0] exp_outst;
        bit              any_out;
        int              g;
        int              c;
        int              p;
        if (areset) begin
            for (int i = 0; i < N; i++) mcnt[i] = 0;
            mpend = 0;
            mrr   = 0;
            merr  = 0;
            chk("rst_s_req_ready", s_req_ready, '0);
            chk("rst_m_req_valid", m_req_valid, '0);
            chk("rst_outst", outst, '0);
            chk("rst_err", err, '0);
            chk("rst_busy", busy, '0);
        end else begin
            g = -1;
            for (int i = 0; i < N; i++)
                elig[i] = s_req_valid[i] && en[i] && (mcnt[i] < MAXO);
            if (!mpend) begin
                for (int k = 0; k < N; k++) begin
                    p = (mrr + k) % N;
                    if (g < 0 && elig[p]) g = p;
                end
            end
            exp_rdy   = (g >= 0) ? (N'(1) << g) : '0;
            exp_outst = '0;
            any_out   = 0;
            for (int i = 0; i < N; i++) begin
                exp_outst[i*CB +: CB] = CB'(mcnt[i]);
                if (mcnt[i] != 0) any_out = 1;
            end
            chk("s_req_ready", s_req_ready, exp_rdy);
            chk("m_req_valid", m_req_valid, mpend);
            if (mpend) begin
                chk("m_req_data", m_req_data, mdata);
                chk("m_req_src", m_req_src, msrc);
            end
            chk("outst", outst, exp_outst);
            chk("err", err, merr);
            chk("busy", busy, mpend || any_out);

            if (g >= 0) begin
                mpend = 1;
                mdata = s_req_data[g*DW +: DW];
                msrc  = g;
            end else if (mpend && m_req_ready) begin
                mpend = 0;
                mrr   = (msrc + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                c = mcnt[i] + ((g == i) ? 1 : 0) - ((cpl_valid && int'(cpl_id) == i) ? 1 : 0);
                if (c < 0) begin
                    c    = 0;
                    merr = 1;
                end
                mcnt[i] = c;
            end
        end
    end

    initial begin
        int            order [8];
        int            exp_order [8];
        logic [DW-1:0] req0;
        exp_order = '{1, 2, 3, 0, 1, 2, 3, 0};

        areset      = 1'b1;
        s_req_valid = '0;
        s_req_data  = '0;
        m_req_ready = 1'b0;
        cpl_valid   = 1'b0;
        cpl_id      = '0;
        en          = '0;
        repeat (3) tick();
        areset = 1'b0;
        #1;
        chk("init_ready", s_req_ready, '0);
        chk("init_mvalid", m_req_valid, '0);
        chk("init_mdata", m_req_data, '0);
        chk("init_msrc", m_req_src, '0);
        chk("init_busy", busy, '0);
        chk("init_err", err, '0);

        // Single requester, len field 0x1000.
        req0 = {64'h0, 32'h0000_1000, 32'hABCD_0001};
        en = 4'b0001;
        s_req_data[0 +: DW] = req0;
        s_req_valid = 4'b0001;
        #1;
        chk("single_ready", s_req_ready, 4'b0001);
        tick();
        s_req_valid = '0;
        #1;
        chk("single_mvalid", m_req_valid, 1'b1);
        chk("single_mdata", m_req_data, req0);
        chk("single_msrc", m_req_src, 0);
        chk("single_outst", outst, 16'h0001);

        // Backpressure while all requesters are asking.
        s_req_valid = 4'hF;
        en = 4'hF;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_mvalid", m_req_valid, 1'b1);
            chk("bp_mdata", m_req_data, req0);
            chk("bp_msrc", m_req_src, 0);
            chk("bp_ready", s_req_ready, '0);
        end
        m_req_ready = 1'b1;
        tick();

        // Round robin resumes after requester 0.
        for (int j = 0; j < 8; j++) begin
            #1;
            order[j] = -1;
            for (int i = 0; i < N; i++)
                if (s_req_ready == (N'(1) << i)) order[j] = i;
            tick();
            tick();
        end
        s_req_valid = '0;
        for (int j = 0; j < 8; j++) chk("rr_order", order[j], exp_order[j]);
        #1;
        chk("rr_outst", outst, 16'h2223);

        // Credit cap on requester 1.
        repeat (6) grant_one(1);
        s_req_valid = 4'b0010;
        #1;
        chk("cap_stall_ready", s_req_ready, '0);
        chk("cap_outst1", outst[1*CB +: CB], 8);
        s_req_valid = 4'b0110;
        #1;
        chk("cap_other_ready", s_req_ready, 4'b0100);
        tick();
        s_req_valid = 4'b0010;
        cpl_valid = 1'b1;
        cpl_id = 2'd1;
        tick();
        cpl_valid = 1'b0;
        #1;
        chk("cap_release_ready", s_req_ready, 4'b0010);
        chk("cap_release_outst1", outst[1*CB +: CB], 7);
        tick();
        s_req_valid = '0;
        tick();

        // Grant and completion on requester 3 in the same cycle.
        repeat (3) grant_one(3);
        #1;
        chk("sim_pre_outst3", outst[3*CB +: CB], 5);
        s_req_valid = 4'b1000;
        cpl_valid = 1'b1;
        cpl_id = 2'd3;
        #1;
        chk("sim_ready", s_req_ready, 4'b1000);
        tick();
        s_req_valid = '0;
        cpl_valid = 1'b0;
        #1;
        chk("sim_outst3", outst[3*CB +: CB], 5);
        tick();

        // Underflow on requester 2.
        chk("under_pre_outst2", outst[2*CB +: CB], 3);
        cpl_valid = 1'b1;
        cpl_id = 2'd2;
        repeat (3) tick();
        chk("under_drain_outst2", outst[2*CB +: CB], 0);
        chk("under_drain_err", err, 1'b0);
        tick();
        cpl_valid = 1'b0;
        #1;
        chk("under_outst2", outst[2*CB +: CB], 0);
        chk("under_err", err, 1'b1);
        repeat (3) tick();
        chk("under_err_sticky", err, 1'b1);

        // Reset in the middle of ST_SEND.
        s_req_valid = 4'b0001;
        m_req_ready = 1'b0;
        tick();
        s_req_valid = '0;
        #1;
        chk("midrst_pre_mvalid", m_req_valid, 1'b1);
        #1;
        areset = 1'b1;
        #1;
        chk("midrst_mvalid", m_req_valid, 1'b0);
        chk("midrst_outst", outst, '0);
        chk("midrst_err", err, 1'b0);
        tick();
        areset = 1'b0;
        s_req_valid = 4'hF;
        en = 4'hF;
        m_req_ready = 1'b1;
        #1;
        chk("midrst_restart", s_req_ready, 4'b0001);

        // Randomized traffic, two completion densities.
        for (int ph = 0; ph < 2; ph++) begin
            for (int cyc = 0; cyc < 1500; cyc++) begin
                s_req_valid = N'($urandom);
                en          = ($urandom_range(0, 7) != 0) ? 4'hF : N'($urandom);
                m_req_ready = ($urandom_range(0, 3) != 0);
                for (int w = 0; w < N*DW/32; w++) s_req_data[w*32 +: 32] = $urandom;
                cpl_valid   = (ph == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
                cpl_id      = IB'($urandom);
                areset      = ($urandom_range(0, 499) == 0);
                tick();
            end
        end
        areset = 1'b0;
        s_req_valid = '0;
        cpl_valid = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dreq_rdma_rd_sched.md
Name: dreq_rdma_rd_sched

Overview:
Round-robin scheduler that shares one RDMA read-request parser between N_REQ requester streams of dreq_t commands, typically one stream per vFPGA. It enforces a per-requester cap on outstanding read commands using completion feedback. It sits upstream of the RDMA read parser, and its m_req port drives that parser's s_req port. It also exposes an enable mask and outstanding counters for configuration and status.

Parameters:
N_REQ, 4, number of requester streams (must be at least 2).
DREQ_BITS, $bits(dreq_t), width of one request word.
MAX_OUTST, 8, maximum outstanding read commands per requester (range 1..2**CRED_BITS-1).
CRED_BITS, 4, width of each outstanding counter.
ID_BITS, $clog2(N_REQ), requester index width.

Ports:
aclk  in  1  clock.
areset  in  1  asynchronous reset, active-high.
s_req_valid  in  N_REQ  per-requester request valid.
s_req_ready  out  N_REQ  per-requester request ready.
s_req_data  in  N_REQ*DREQ_BITS  request words; requester i occupies bits [i*DREQ_BITS +: DREQ_BITS].
m_req_valid  out  1  request valid toward the parser.
m_req_ready  in  1  parser ready.
m_req_data  out  DREQ_BITS  granted request word, passed unmodified.
m_req_src  out  ID_BITS  index of the granted requester.
cpl_valid  in  1  pulse: one full read command (last chunk) completed.
cpl_id  in  ID_BITS  requester index of the completion.
en  in  N_REQ  requester enable mask (configuration).
outst  out  N_REQ*CRED_BITS  per-requester outstanding counters.
busy  out  1  high when state is not ST_IDLE or any counter is nonzero.
err  out  1  sticky: a completion arrived for a requester whose counter was zero.

Behaviour:
- Reset (asynchronous, immediate):
  - state = ST_IDLE, rr_ptr = 0, all counters = 0, err = 0.
  - s_req_ready = 0, m_req_valid = 0, m_req_data = 0, m_req_src = 0, busy = 0.
  - A reset during ST_SEND discards the latched request. No partial handshake survives reset.
- Eligibility: requester i is eligible when s_req_valid[i] & en[i] & (outst[i] < MAX_OUTST).
- FSM states: ST_IDLE, ST_SEND.
- ST_IDLE:
  - If any requester is eligible, grant g = the first eligible index at or after rr_ptr, searching modulo N_REQ.
  - s_req_ready is one-hot at bit g in this cycle only (combinational).
  - At the clock edge: latch s_req_data[g] into m_req_data and g into m_req_src, increment outst[g], and go to ST_SEND.
  - If no requester is eligible, s_req_ready = 0 and the FSM stays in ST_IDLE.
- ST_SEND:
  - m_req_valid = 1. m_req_data and m_req_src stay stable until the handshake.
  - On m_req_ready: rr_ptr = (g+1) mod N_REQ, then go to ST_IDLE.
  - s_req_ready = 0 throughout.
- Timing: first grant to m_req_valid is 1 cycle. Peak throughput is one command per 2 cycles, which matches the parser's minimum of 2 cycles per command.
- m_req_valid is registered and never depends combinationally on m_req_ready.
- Counters:
  - A cpl_valid pulse decrements outst[cpl_id] by 1.
  - A grant increment and a completion decrement for the same index in the same cycle leave the counter unchanged.
  - A completion for an index whose counter is 0 leaves the counter at 0 (saturating) and sets err.
  - cpl_id >= N_REQ is ignored and sets err.
- The enable mask is sampled only in ST_IDLE for eligibility.
  - Deasserting en[g] during ST_SEND does not cancel the latched request.
  - Completions for disabled requesters still decrement.
- Fairness: each eligible requester is granted at least once every N_REQ grants.
- s_req_ready is never asserted toward a requester whose valid is low.

Test Plan:
- Single requester: en=4'b0001, req0 valid with len=0x1000 -> s_req_ready[0] pulses 1 cycle; m_req_valid next cycle with identical data, m_req_src=0; outst[0]=1.
- All four requesters valid continuously, m_req_ready=1, rr_ptr=0 -> grant order 0,1,2,3,0,... with one grant every 2 cycles; counters increase uniformly.
- Credit cap, MAX_OUTST=8: req1 issues 8 commands with no completions -> the 9th stalls (s_req_ready[1]=0) while req2 is still granted; one cpl_valid with cpl_id=1 -> req1 is granted on the next ST_IDLE cycle.
- Simultaneous grant and completion for requester 3 with outst[3]=5 -> outst[3] stays 5; a lone completion for requester 2 with outst[2]=0 -> counter stays 0 and err=1 (sticky).
- Backpressure: m_req_ready held 0 for 10 cycles in ST_SEND -> m_req_valid, m_req_data and m_req_src are stable for all 10 cycles; no other s_req_ready is asserted.
- areset asserted mid-ST_SEND -> m_req_valid drops to 0 without waiting for a clock edge; all counters and err are 0; after release, arbitration restarts from requester 0.
